dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-side memory responder: the far end of the datapath's M-stage data port.
//  Accepts read/write requests as the pipeline emits them (byte-lane enables, word
//  address, lane-aligned write data) and services them from internal word storage
//  with a fixed multi-cycle latency. Returns the raw 32-bit word, which the M-stage
//  load decoder extracts and extends. Drives stallreq so the hazard unit freezes
//  the pipeline until the access completes.
// PARAMETERS
//  DEPTH_LOG2  10  log2 of storage depth in 32-bit words (word index = addr[DEPTH_LOG2+1:2])
//  LATENCY     2   BUSY cycles per access; legal range 1..15
// PORTS
//  clk       in   1   clock; all state updates on posedge
//  rst       in   1   asynchronous reset, active-low
//  rd_en     in   4   read byte-lane enables; any bit set = read request
//  wr_en     in   4   write byte-lane enables; bit i writes wdata[8i+7:8i]
//  addr      in   32  byte address; bits [1:0] ignored, lanes come from enables
//  wdata     in   32  lane-aligned write data
//  size      in   2   access size (0 byte, 1 half, 2 word); informational only
//  stall_all in   1   pipeline M stage held this cycle for a reason other than stallreq
//  flush     in   1   exception flush of M stage (flush_except)
//  rdata     out  32  read word; valid in DONE, held until the next read commits
//  stallreq  out  1   request pipeline stall (stallreq_from_mem)
//  bus_err   out  1   access-fault pulse (DMEM_BUS_ERR_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, cnt=0, rdata=0, bus_err=0, latched request
//    cleared. Storage is not initialised. Reset in mid-access drops the access, and a
//    pending write is never committed.
//  - req = |rd_en | |wr_en. stallreq = (IDLE & req & ~flush) | BUSY. Combinational,
//    so the pipeline stalls in the same cycle the request appears.
//  - IDLE: if req & ~flush, latch addr/wdata/rd_en/wr_en, load cnt=LATENCY-1, go BUSY.
//  - BUSY: if flush, go IDLE (abort; no write, rdata unchanged). Else if cnt!=0,
//    cnt--. Else commit: for each i with wr_en[i], write byte lane i. If rd_en!=0,
//    rdata <= stored word before the write. Go DONE.
//  - DONE: stallreq=0, rdata stable. If ~stall_all | flush, go IDLE; else hold.
//    DONE blocks re-issue of the request that is still on the port while frozen.
//  - Timing, request first visible in cycle 0: stallreq high cycles 0..LATENCY,
//    rdata valid and stallreq low in cycle LATENCY+1.
//  - rd_en and wr_en both nonzero: both are performed. rdata returns the pre-write word.
//  - Index wrap: upper address bits above DEPTH_LOG2+1 are ignored, so the address
//    aliases modulo the depth (macro off).
//  - Back-to-back requests: the earliest acceptance is the cycle after DONE exits.
// CONFIGURATION
//  DMEM_BUS_ERR_EN defined:
//    - addr[31:DEPTH_LOG2+2] != 0 marks the access out of range.
//    - At commit there is no write, rdata <= 0, and bus_err = 1 for exactly the one
//      cycle in DONE entry. The timing is otherwise identical.
//  DMEM_BUS_ERR_EN undefined: bus_err is constant 0 and addresses alias (see above).
// TESTING
//  T1 word write/read:
//    - wr_en=F, addr=0x10, wdata=0xDEADBEEF, then rd_en=F, addr=0x10.
//    - Each access: stallreq 3 cycles (LATENCY=2). Read gives rdata=0xDEADBEEF.
//  T2 byte lane:
//    - Preload 0x11223344 at 0x20. Write wr_en=0010, wdata=0x0000AB00.
//    - Read returns 0x1122AB44.
//  T3 flush mid-read:
//    - Assert flush in the first BUSY cycle.
//    - FSM goes IDLE next cycle, stallreq drops, rdata keeps its old value.
//  T4 frozen pipe:
//    - Hold stall_all=1 for 4 cycles after DONE with the request held.
//    - No second access (cnt idle), rdata stable. IDLE the cycle after stall_all=0.
//  T5 reset mid-write:
//    - Pull rst low during BUSY of a write to 0x30.
//    - All outputs go to reset values, and a later read of 0x30 shows the old data.
//  T6 (macro on):
//    - Read addr=0x8000_0000 with DEPTH_LOG2=10.
//    - rdata=0, bus_err pulses exactly 1 cycle, stallreq timing unchanged.

Source files
------------

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_responder: M-stage data memory, fixed-latency byte-lane word store  |
// | Optional DMEM_BUS_ERR_EN: out-of-range access fault. Rev 1.0             |
// +--------------------------------------------------------------------------+
module dmem_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  rd_en,
    input  logic [3:0]  wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        stall_all,
    input  logic        flush,
    output logic [31:0] rdata,
    output logic        stallreq,
    output logic        bus_err
);

    localparam int         c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wr_en;
    logic                  r_rd;
    logic                  r_oob;
    logic [31:0]           r_mem [c_DEPTH];

    logic w_req;
    logic w_oob;
    logic w_commit;

    assign w_req    = (|rd_en) | (|wr_en);
    assign stallreq = ((r_state == S_IDLE) & w_req & ~flush) | (r_state == S_BUSY);
    assign w_commit = (r_state == S_BUSY) & ~flush & (r_cnt == 4'd0);

`ifdef DMEM_BUS_ERR_EN
    assign w_oob = |addr[31:DEPTH_LOG2+2];
`else
    // Upper address bits are dropped, so the store aliases modulo its depth.
    assign w_oob = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{size, addr[1:0], addr[31:DEPTH_LOG2+2]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_wr_en <= 4'd0;
            r_rd    <= 1'b0;
            r_oob   <= 1'b0;
            rdata   <= 32'd0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req & ~flush) begin
                        r_idx   <= addr[DEPTH_LOG2+1:2];
                        r_wdata <= wdata;
                        r_wr_en <= wr_en;
                        r_rd    <= |rd_en;
                        r_oob   <= w_oob;
                        r_cnt   <= c_CNT_LOAD;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        r_cnt   <= 4'd0;
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Read samples the word before this edge's lane writes land.
                        if (r_oob) begin
                            rdata   <= 32'd0;
                            bus_err <= 1'b1;
                        end else if (r_rd) begin
                            rdata <= r_mem[r_idx];
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Holding here while frozen keeps the same request from re-issuing.
                    if (~stall_all | flush) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit & ~r_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (r_wr_en[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_responder: directed self-checking bench for dmem_responder       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic [3:0]  rd_en;
    logic [3:0]  wr_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        stall_all;
    logic        flush;
    logic [31:0] rdata;
    logic        stallreq;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .addr      (addr),
        .wdata     (wdata),
        .size      (size),
        .stall_all (stall_all),
        .flush     (flush),
        .rdata     (rdata),
        .stallreq  (stallreq),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a request, count stall cycles up to DONE, then release the port.
    task automatic access(input logic [3:0] r, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] d,
                          output int n, output logic [31:0] got,
                          output logic be_done, output logic be_after);
        rd_en = r;
        wr_en = w;
        addr  = a;
        wdata = d;
        n     = 0;
        #1;
        while (stallreq && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        got     = rdata;
        be_done = bus_err;
        #1;
        rd_en = 4'd0;
        wr_en = 4'd0;
        step();
        #1;
        be_after = bus_err;
    endtask

    int          n;
    logic [31:0] got;
    logic        bd;
    logic        ba;

    initial begin
        rst       = 1'b0;
        rd_en     = 4'd0;
        wr_en     = 4'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        size      = 2'd2;
        stall_all = 1'b0;
        flush     = 1'b0;
        repeat (2) step();
        check("rst_rdata", rdata, 32'd0);
        check("rst_stallreq", {31'd0, stallreq}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        rst = 1'b1;
        step();

        // T1: word write then read
        access(4'h0, 4'hF, 32'h10, 32'hDEADBEEF, n, got, bd, ba);
        check("t1_wr_stall", n, 3);
        access(4'hF, 4'h0, 32'h10, 32'h0, n, got, bd, ba);
        check("t1_rd_stall", n, 3);
        check("t1_rd_data", got, 32'hDEADBEEF);
        check("t1_bus_err", {31'd0, bd}, 32'd0);

        // T2: single byte lane update, then combined read+write
        access(4'h0, 4'hF, 32'h20, 32'h11223344, n, got, bd, ba);
        access(4'h0, 4'b0010, 32'h20, 32'h0000AB00, n, got, bd, ba);
        access(4'hF, 4'h0, 32'h20, 32'h0, n, got, bd, ba);
        check("t2_lane_data", got, 32'h1122AB44);
        access(4'hF, 4'b0001, 32'h20, 32'h000000CC, n, got, bd, ba);
        check("t2_rw_pre", got, 32'h1122AB44);
        access(4'hF, 4'h0, 32'h20, 32'h0, n, got, bd, ba);
        check("t2_rw_post", got, 32'h1122ABCC);

        // T3: flush in the first BUSY cycle aborts the read
        rd_en = 4'hF;
        addr  = 32'h10;
        step();
        flush = 1'b1;
        rd_en = 4'h0;
        #1;
        check("t3_busy_stall", {31'd0, stallreq}, 32'd1);
        step();
        flush = 1'b0;
        #1;
        check("t3_idle_stall", {31'd0, stallreq}, 32'd0);
        check("t3_rdata_kept", rdata, 32'h1122ABCC);
        repeat (3) step();
        check("t3_rdata_later", rdata, 32'h1122ABCC);
        // flush in IDLE suppresses acceptance
        rd_en = 4'hF;
        flush = 1'b1;
        #1;
        check("t3_flush_idle", {31'd0, stallreq}, 32'd0);
        step();
        rd_en = 4'h0;
        flush = 1'b0;
        #1;
        check("t3_not_taken", {31'd0, stallreq}, 32'd0);

        // T4: frozen pipe holds DONE with the request still present
        rd_en = 4'hF;
        addr  = 32'h10;
        n     = 0;
        #1;
        while (stallreq && n < 40) begin
            n++;
            @(posedge clk);
            #2;
        end
        check("t4_stall", n, 3);
        #1;
        stall_all = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            check("t4_frozen_stall", {31'd0, stallreq}, 32'd0);
            check("t4_frozen_rdata", rdata, 32'hDEADBEEF);
        end
        stall_all = 1'b0;
        rd_en     = 4'h0;
        step();
        #1;
        check("t4_idle", {31'd0, stallreq}, 32'd0);
        rd_en = 4'hF;
        #1;
        check("t4_accepts", {31'd0, stallreq}, 32'd1);
        rd_en = 4'h0;
        #1;

        // T5: reset during the BUSY phase of a write
        access(4'h0, 4'hF, 32'h30, 32'hCAFEF00D, n, got, bd, ba);
        access(4'hF, 4'h0, 32'h20, 32'h0, n, got, bd, ba);
        wr_en = 4'hF;
        addr  = 32'h30;
        wdata = 32'h12345678;
        step();
        rst   = 1'b0;
        wr_en = 4'h0;
        #1;
        check("t5_rst_stall", {31'd0, stallreq}, 32'd0);
        check("t5_rst_rdata", rdata, 32'd0);
        check("t5_rst_bus_err", {31'd0, bus_err}, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        step();
        access(4'hF, 4'h0, 32'h30, 32'h0, n, got, bd, ba);
        check("t5_old_data", got, 32'hCAFEF00D);
        check("t5_stall", n, 3);

`ifdef DMEM_BUS_ERR_EN
        // T6: out-of-range read returns zero with a one-cycle fault pulse
        access(4'hF, 4'h0, 32'h8000_0000, 32'h0, n, got, bd, ba);
        check("t6_stall", n, 3);
        check("t6_rdata", got, 32'd0);
        check("t6_bus_err_on", {31'd0, bd}, 32'd1);
        check("t6_bus_err_off", {31'd0, ba}, 32'd0);
`else
        // Upper address bits alias onto the low store
        access(4'h0, 4'hF, 32'h1010, 32'h5A5A5A5A, n, got, bd, ba);
        check("alias_wr_stall", n, 3);
        access(4'hF, 4'h0, 32'h10, 32'h0, n, got, bd, ba);
        check("alias_data", got, 32'h5A5A5A5A);
        check("alias_bus_err", {31'd0, bd}, 32'd0);
        check("alias_bus_err2", {31'd0, ba}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
